regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback_if.sv | 39 +++
 rtl/regfile_writeback.sv | 124 ++++++++++++
 tb/tb_regfile_writeback.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_if.sv
// Producer handshakes and register-file write port of the writeback block.
interface regfile_writeback_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned NREG  = 2 ** ADDR_W;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;

    logic [NREG-1:0]   pending;
    logic [CNT_W-1:0]  count;
    logic              idle;

    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready, rf_write_enable, rf_write_addr, rf_write_data,
        input  pending, count, idle
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready, rf_write_enable, rf_write_addr, rf_write_data,
        output pending, count, idle
    );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file writer: round-robin accepts ALU/load results into a FIFO and
// issues one registered register-file write per cycle in acceptance order.
module regfile_writeback #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input logic               clk,
    input logic               reset_n,
    regfile_writeback_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NREG  = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    entry_t            fifo [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    grant_t            last_grant;
    logic              rf_enable;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;

    logic              full;
    logic              alu_ready;
    logic              mem_ready;
    logic              alu_fire;
    logic              mem_fire;
    logic              push;
    logic              pop;
    entry_t            push_entry;
    logic [NREG-1:0]   pend;
    logic [PTR_W-1:0]  idx;

    // Ready never looks at the producer's own valid; a contended edge goes to the
    // producer that did not win the last transfer.
    always_comb begin
        full       = (count == CNT_W'(DEPTH));
        alu_ready  = reset_n && !full && (!bus.mem_valid || last_grant == GRANT_MEM);
        mem_ready  = reset_n && !full && (!bus.alu_valid || last_grant == GRANT_ALU);
        alu_fire   = bus.alu_valid && alu_ready;
        mem_fire   = bus.mem_valid && mem_ready;
        push       = alu_fire || mem_fire;
        pop        = (count != '0);
        push_entry = alu_fire ? entry_t'{addr: bus.alu_addr, data: bus.alu_data}
                              : entry_t'{addr: bus.mem_addr, data: bus.mem_data};
    end

    // Queue storage needs no reset: only slots inside count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_grant <= GRANT_ALU;
            rf_enable  <= 1'b0;
            rf_addr    <= '0;
            rf_data    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                rf_enable <= 1'b1;
                rf_addr   <= fifo[rd_ptr].addr;
                rf_data   <= fifo[rd_ptr].data;
            end else begin
                rf_enable <= 1'b0;
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
            if (alu_fire) begin
                last_grant <= GRANT_ALU;
            end else if (mem_fire) begin
                last_grant <= GRANT_MEM;
            end
        end
    end

    // Scoreboard view: every live queue slot plus the write on the output stage.
    always_comb begin
        pend = '0;
        idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                pend[fifo[idx].addr] = 1'b1;
            end
        end
        if (rf_enable) begin
            pend[rf_addr] = 1'b1;
        end
    end

    assign bus.alu_ready       = alu_ready;
    assign bus.mem_ready       = mem_ready;
    assign bus.rf_write_enable = rf_enable;
    assign bus.rf_write_addr   = rf_addr;
    assign bus.rf_write_data   = rf_data;
    assign bus.pending         = pend;
    assign bus.count           = count;
    assign bus.idle            = (count == '0) && !rf_enable;
endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback against a queue-based model.
module tb_regfile_writeback;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    regfile_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus();

    regfile_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Model: pending writes in acceptance order, the output stage, and who won last.
    wr_t               q[$];
    bit                m_en;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    bit                m_last_mem;
    logic [ADDR_W-1:0] dut_log[$];
    logic [DATA_W-1:0] rf_arr[32];
    int                max_cnt;
    int                checks = 0;
    int                errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                         input bit mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md);
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
    endtask

    // One clock: check combinational outputs for the driven inputs, advance the
    // model across the edge, then check the registered write port.
    task automatic step();
        bit                exp_ar, exp_mr, full, take_alu, take_mem;
        logic [31:0]       exp_pend;
        wr_t               cand_alu, cand_mem, head;
        #1;
        full = (q.size() == DEPTH);
        if (!reset_n || full) begin
            exp_ar = 1'b0;
            exp_mr = 1'b0;
        end else begin
            exp_ar = !bus.mem_valid || m_last_mem;
            exp_mr = !bus.alu_valid || !m_last_mem;
        end
        exp_pend = '0;
        foreach (q[i]) exp_pend[q[i].addr] = 1'b1;
        if (m_en) exp_pend[m_addr] = 1'b1;
        check_eq("alu_ready", 64'(bus.alu_ready), 64'(exp_ar));
        check_eq("mem_ready", 64'(bus.mem_ready), 64'(exp_mr));
        check_eq("count", 64'(bus.count), 64'(q.size()));
        check_eq("pending", 64'(bus.pending), 64'(exp_pend));
        check_eq("idle", 64'(bus.idle), 64'(q.size() == 0 && !m_en));
        if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
        take_alu = bus.alu_valid && exp_ar;
        take_mem = bus.mem_valid && exp_mr;
        cand_alu.addr = bus.alu_addr;
        cand_alu.data = bus.alu_data;
        cand_mem.addr = bus.mem_addr;
        cand_mem.data = bus.mem_data;
        @(posedge clk);
        if (!reset_n) begin
            q.delete();
            m_en       = 1'b0;
            m_addr     = '0;
            m_data     = '0;
            m_last_mem = 1'b0;
        end else begin
            if (q.size() > 0) begin
                head   = q.pop_front();
                m_en   = 1'b1;
                m_addr = head.addr;
                m_data = head.data;
            end else begin
                m_en = 1'b0;
            end
            if (take_alu) begin
                q.push_back(cand_alu);
                m_last_mem = 1'b0;
            end else if (take_mem) begin
                q.push_back(cand_mem);
                m_last_mem = 1'b1;
            end
        end
        #1;
        check_eq("rf_write_enable", 64'(bus.rf_write_enable), 64'(m_en));
        check_eq("rf_write_addr", 64'(bus.rf_write_addr), 64'(m_addr));
        check_eq("rf_write_data", bus.rf_write_data, m_data);
        if (bus.rf_write_enable) begin
            dut_log.push_back(bus.rf_write_addr);
            rf_arr[bus.rf_write_addr] = bus.rf_write_data;
        end
    endtask

    task automatic idle_steps(input int n);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [ADDR_W-1:0] exp_order[$];
        m_en = 1'b0; m_addr = '0; m_data = '0; m_last_mem = 1'b0; max_cnt = 0;
        foreach (rf_arr[i]) rf_arr[i] = '0;
        drive(1'b1, 5'd3, 64'd1, 1'b1, 5'd4, 64'd2);
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        idle_steps(1);

        // Single ALU write to r2
        dut_log.delete();
        drive(1'b1, 5'd2, 64'hAA55AA55AA55AA55, 1'b0, '0, '0);
        step();
        idle_steps(3);
        check_eq("single_count", 64'(dut_log.size()), 64'd1);
        if (dut_log.size() == 1) check_eq("single_addr", 64'(dut_log[0]), 64'd2);
        check_eq("single_rf", rf_arr[2], 64'hAA55AA55AA55AA55);

        // Contention: load wins first, then alternation
        dut_log.delete();
        drive(1'b1, 5'd5, 64'd12, 1'b1, 5'd10, 64'd14);
        for (int i = 0; i < 4; i++) step();
        idle_steps(3);
        exp_order = '{5'd10, 5'd5, 5'd10, 5'd5};
        check_eq("contend_count", 64'(dut_log.size()), 64'd4);
        foreach (exp_order[i]) if (i < dut_log.size()) check_eq("contend_order", 64'(dut_log[i]), 64'(exp_order[i]));

        // Five back-to-back ALU writes r1..r5
        dut_log.delete();
        max_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, ADDR_W'(i), 64'(i * 100), 1'b0, '0, '0);
            step();
        end
        idle_steps(3);
        check_eq("full_count_bound", 64'(max_cnt <= DEPTH), 64'd1);
        check_eq("full_issue_count", 64'(dut_log.size()), 64'd5);
        for (int i = 0; i < 5; i++) if (i < dut_log.size()) check_eq("full_order", 64'(dut_log[i]), 64'(i + 1));

        // Same register twice: later value wins
        drive(1'b1, 5'd7, 64'd1, 1'b0, '0, '0);
        step();
        drive(1'b1, 5'd7, 64'd2, 1'b0, '0, '0);
        step();
        idle_steps(3);
        check_eq("same_reg_final", rf_arr[7], 64'd2);

        // Reset in flight discards outstanding writes
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ADDR_W'(20 + i), 64'(i), 1'b0, '0, '0);
            step();
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        dut_log.delete();
        idle_steps(4);
        check_eq("reset_no_issue", 64'(dut_log.size()), 64'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(1)), ADDR_W'($urandom_range(31)), {$urandom, $urandom},
                  1'($urandom_range(1)), ADDR_W'($urandom_range(31)), {$urandom, $urandom});
            reset_n = ($urandom_range(49) != 0);
            step();
        end
        reset_n = 1'b1;
        idle_steps(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
